sum_uart_tx: RTL

//  Downstream stage of the 4-bit adder: latches the 5-bit sum on a user "send" pulse and

---
 rtl/sum_uart_pkg.sv | 20 ++
 rtl/sum_uart_tx_core.sv | 107 ++++++++++
 rtl/sum_uart_tx.sv | 67 ++++++
 3 files changed

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the adder-sum UART transmitter.
// Frame layout: one start bit, DATA_W data bits LSB first, one stop bit.
package sum_uart_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clock cycles from tx falling to busy falling for a given bit period.
    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/sum_uart_tx_core.sv
// UART 8N1 serializer: baud counter, shift register and frame FSM.
// A start request in IDLE loads the byte and drives the start bit on the same edge.
module sum_uart_tx_core
    import sum_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_byte,
    input  logic              i_start,
    output logic              o_tx,
    output logic              o_busy
);

    localparam int unsigned           CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned           IDX_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(DATA_W - 1);

    uart_state_e       r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_busy;
    logic              w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Frame FSM; tx always carries the bit of the state just entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_cnt  <= '0;
                    r_idx  <= '0;
                    if (i_start) begin
                        r_state <= START;
                        r_shift <= i_byte;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == IDX_LAST) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = r_busy;

    // Line must idle high and busy must track "not IDLE" exactly.
    a_idle_line_high: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == IDLE) |-> r_tx);
    a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        r_busy == (r_state != IDLE));

endmodule

// File: rtl/sum_uart_tx.sv
// Latches the adder sum on a rising edge of the asynchronous send request
// and transmits it zero-extended as one UART 8N1 byte.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned SUM_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             send,
    output logic             tx,
    output logic             busy,
    output logic [SUM_W-1:0] latched_sum
);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;
    logic [SUM_W-1:0]  r_latched;
    logic              w_start_pulse;
    logic              w_busy;
    logic              w_tx;
    logic [DATA_W-1:0] w_byte;

    // Sync flops reset high so a send held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= send;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_start_pulse = r_sync2 & ~r_sync3;
    assign w_byte        = DATA_W'(sum_in);

    // Capture only when the core will accept the request, so a dropped pulse leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latched <= '0;
        end else if (w_start_pulse && !w_busy) begin
            r_latched <= sum_in;
        end
    end

    sum_uart_tx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_byte  (w_byte),
        .i_start (w_start_pulse),
        .o_tx    (w_tx),
        .o_busy  (w_busy)
    );

    assign tx          = w_tx;
    assign busy        = w_busy;
    assign latched_sum = r_latched;

endmodule
